// File: rtl/clock_module.sv
// ---------------------------------------------------------------------------
// clock_module
//
// Generates the ASAP-1 CPU clock from the board oscillator. Three push
// buttons control it.
//   start/stop : toggles between free-run and halt
//   step       : emits one clock pulse while halted
//   speed      : cycles through four free-run rates (HALF_BASE >> 0..3)
//
// Each button passes through a 2-flop synchronizer, a polarity normaliser
// and a counter-based debouncer. The debouncer emits a one-cycle press
// pulse on each released->pressed transition.
//
// Ports
//   clk_i             in   board oscillator, the only clock in the block
//   rst               in   asynchronous active-low reset
//   clk_start_stop_i  in   raw button, toggles run/halt
//   clk_step_i        in   raw button, single step while halted
//   clk_speed_i       in   raw button, advances the speed index
//   clk               out  generated CPU clock, driven directly by a flop
//
// HALF_BASE must be at least 8 so that the fastest speed still has a
// half-period of one or more oscillator cycles.
// ---------------------------------------------------------------------------
module clock_module #(
    parameter int unsigned HALF_BASE       = 25_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 500_000,
    parameter bit          BTN_ACTIVE_LOW  = 1'b0,
    parameter bit          RUN_AT_RESET    = 1'b0
) (
    input  logic clk_i,
    input  logic rst,
    input  logic clk_start_stop_i,
    input  logic clk_step_i,
    input  logic clk_speed_i,
    output logic clk
);

    localparam int unsigned NUM_BTN   = 3;
    localparam int unsigned BTN_START = 0;
    localparam int unsigned BTN_STEP  = 1;
    localparam int unsigned BTN_SPEED = 2;

    localparam int unsigned PHASE_W = $clog2(HALF_BASE + 1);
    localparam int unsigned DEB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [DEB_W-1:0]   DEB_LAST     = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [NUM_BTN-1:0] RAW_RELEASED = {NUM_BTN{BTN_ACTIVE_LOW}};

    // ------------------------------------------------------------------
    // Button synchronizers
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] sync1_q, sync1_d;
    logic [NUM_BTN-1:0] sync2_q, sync2_d;
    logic [NUM_BTN-1:0] btn_level;

    assign btn_raw = {clk_speed_i, clk_step_i, clk_start_stop_i};

    // After normalisation, 1 always means pressed regardless of polarity.
    assign btn_level = sync2_q ^ RAW_RELEASED;

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            sync1_q <= RAW_RELEASED;
            sync2_q <= RAW_RELEASED;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    // ------------------------------------------------------------------
    // Debouncers
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] deb_q, deb_d;
    logic [NUM_BTN-1:0] press_q, press_d;
    logic [DEB_W-1:0]   deb_cnt_q [NUM_BTN];
    logic [DEB_W-1:0]   deb_cnt_d [NUM_BTN];

    // The counter only advances while the sampled level disagrees with the
    // debounced level. The sample that would reach DEBOUNCE_CYCLES flips
    // the level instead. A press pulse is raised only for the flip toward
    // pressed.
    always_comb begin
        deb_d   = deb_q;
        press_d = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            deb_cnt_d[i] = '0;
            if (btn_level[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    deb_d[i]   = btn_level[i];
                    press_d[i] = btn_level[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            deb_q   <= '0;
            press_q <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            deb_q   <= deb_d;
            press_q <= press_d;
            for (int i = 0; i < NUM_BTN; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Clock generator
    // ------------------------------------------------------------------
    logic               run_q, run_d;
    logic [1:0]         speed_q, speed_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               step_busy_q, step_busy_d;
    logic               clk_q, clk_d;

    logic               start_stop_ev;
    logic               step_ev;
    logic               speed_ev;
    logic               step_start;
    logic [PHASE_W-1:0] limit_m1;
    logic               phase_end;

    assign start_stop_ev = press_q[BTN_START];
    assign step_ev       = press_q[BTN_STEP];
    assign speed_ev      = press_q[BTN_SPEED];

    // The limit follows the registered speed, so a speed change is seen on
    // the very next edge. Using >= ends an over-long phase at once when the
    // limit shrinks.
    assign limit_m1  = PHASE_W'(HALF_BASE >> speed_q) - PHASE_W'(1);
    assign phase_end = (phase_q >= limit_m1);

    // A step may only start from a fully idle low level. Start/stop in the
    // same cycle takes priority over it.
    assign step_start = step_ev & ~start_stop_ev & ~run_q & ~step_busy_q & ~clk_q;

    // A high phase always runs to completion, whether it comes from a step,
    // from free run or from a stop arriving mid-phase. A low phase only
    // counts while running. Otherwise the counter is held clear, which also
    // makes a start press restart the low phase from zero.
    always_comb begin
        run_d       = run_q ^ start_stop_ev;
        speed_d     = speed_q + {1'b0, speed_ev};
        clk_d       = clk_q;
        phase_d     = phase_q;
        step_busy_d = step_busy_q;

        if (step_start) begin
            clk_d       = 1'b1;
            phase_d     = '0;
            step_busy_d = 1'b1;
        end else if (clk_q) begin
            if (phase_end) begin
                clk_d       = 1'b0;
                phase_d     = '0;
                step_busy_d = 1'b0;
            end else begin
                phase_d = phase_q + PHASE_W'(1);
            end
        end else if (run_q && !start_stop_ev) begin
            if (phase_end) begin
                clk_d   = 1'b1;
                phase_d = '0;
            end else begin
                phase_d = phase_q + PHASE_W'(1);
            end
        end else begin
            phase_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            run_q       <= RUN_AT_RESET;
            speed_q     <= 2'd0;
            phase_q     <= '0;
            step_busy_q <= 1'b0;
            clk_q       <= 1'b0;
        end else begin
            run_q       <= run_d;
            speed_q     <= speed_d;
            phase_q     <= phase_d;
            step_busy_q <= step_busy_d;
            clk_q       <= clk_d;
        end
    end

    assign clk = clk_q;

endmodule

// File: tb/tb_clock_module.sv
// ---------------------------------------------------------------------------
// tb_clock_module
//
// Drives the three raw buttons of clock_module with directed sequences and
// random activity. A behavioural model predicts every transition of the
// generated clock and pushes it into a queue. A monitor pops an entry each
// time the DUT clock changes and compares the cycle and the level.
// Directed phases also check periods, pulse widths and edge counts against
// constants derived from HALF_BASE.
// ---------------------------------------------------------------------------
module tb_clock_module;

    localparam int HB  = 8;
    localparam int DEB = 4;

    logic clk_i     = 1'b0;
    logic rst       = 1'b1;
    logic ss_raw    = 1'b0;
    logic step_raw  = 1'b0;
    logic speed_raw = 1'b0;
    logic clk;

    clock_module #(
        .HALF_BASE      (HB),
        .DEBOUNCE_CYCLES(DEB),
        .BTN_ACTIVE_LOW (1'b0),
        .RUN_AT_RESET   (1'b0)
    ) dut (
        .clk_i           (clk_i),
        .rst             (rst),
        .clk_start_stop_i(ss_raw),
        .clk_step_i      (step_raw),
        .clk_speed_i     (speed_raw),
        .clk             (clk)
    );

    initial forever #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic set_raw(input int b, input logic v);
        case (b)
            0:       ss_raw    = v;
            1:       step_raw  = v;
            default: speed_raw = v;
        endcase
    endtask

    function automatic int raw_level(input int b);
        case (b)
            0:       return int'(ss_raw);
            1:       return int'(step_raw);
            default: return int'(speed_raw);
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Reference model: buttons seen two cycles late. A level is accepted
    // after DEB consecutive disagreeing samples. A press acts on the cycle
    // after it is accepted. The clock is described as time spent in the
    // current phase against the limit of the current speed.
    // ------------------------------------------------------------------
    typedef struct {
        int cyc;
        int lvl;
    } edge_t;

    edge_t exp_q[$];
    int    cyc = 0;

    int m_h1[3], m_h2[3], m_deb[3], m_streak[3], m_ev[3];
    int m_clk = 0, m_run = 0, m_speed = 0, m_elapsed = 0, m_busy = 0;
    int m_limit, m_new_clk, m_sample;

    initial begin
        for (int b = 0; b < 3; b++) begin
            m_h1[b] = 0; m_h2[b] = 0; m_deb[b] = 0; m_streak[b] = 0; m_ev[b] = 0;
        end
        forever begin
            @(posedge clk_i or negedge rst);
            if (!rst) begin
                for (int b = 0; b < 3; b++) begin
                    m_h1[b] = 0; m_h2[b] = 0; m_deb[b] = 0; m_streak[b] = 0; m_ev[b] = 0;
                end
                m_clk = 0; m_run = 0; m_speed = 0; m_elapsed = 0; m_busy = 0;
            end else begin
                cyc++;
                m_limit   = HB >> m_speed;
                m_new_clk = m_clk;
                if (m_ev[1] == 1 && m_ev[0] == 0 && m_run == 0 && m_busy == 0 && m_clk == 0) begin
                    m_new_clk = 1;
                    m_busy    = 1;
                    m_elapsed = 0;
                end else if (m_clk == 1 || (m_run == 1 && m_ev[0] == 0)) begin
                    if (m_elapsed + 1 >= m_limit) begin
                        m_new_clk = 1 - m_clk;
                        m_elapsed = 0;
                        if (m_clk == 1) m_busy = 0;
                    end else begin
                        m_elapsed++;
                    end
                end else begin
                    m_elapsed = 0;
                end
                if (m_new_clk != m_clk) exp_q.push_back('{cyc, m_new_clk});
                m_clk = m_new_clk;
                if (m_ev[0] == 1) m_run = 1 - m_run;
                if (m_ev[2] == 1) m_speed = (m_speed + 1) % 4;

                for (int b = 0; b < 3; b++) begin
                    m_sample = m_h2[b];
                    m_h2[b]  = m_h1[b];
                    m_h1[b]  = raw_level(b);
                    m_ev[b]  = 0;
                    if (m_sample != m_deb[b]) begin
                        m_streak[b]++;
                        if (m_streak[b] == DEB) begin
                            m_deb[b]    = m_sample;
                            m_streak[b] = 0;
                            m_ev[b]     = m_sample;
                        end
                    end else begin
                        m_streak[b] = 0;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor: each DUT clock change consumes one predicted transition.
    // It also records rise counts, periods and high widths.
    // ------------------------------------------------------------------
    int    prev_clk    = 0;
    int    rise_count  = 0;
    int    last_rise   = 0;
    int    last_period = 0;
    int    last_high   = 0;
    edge_t mon_e;

    initial forever begin
        @(posedge clk_i);
        #1;
        if (!rst) begin
            prev_clk = 0;
        end else if (int'(clk) != prev_clk) begin
            checkOutput("sb_edge_pending", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                checkOutput("sb_edge_cycle", cyc, mon_e.cyc);
                checkOutput("sb_edge_level", int'(clk), mon_e.lvl);
            end
            if (clk) begin
                rise_count++;
                last_period = cyc - last_rise;
                last_rise   = cyc;
            end else begin
                last_high = cyc - last_rise;
            end
            prev_clk = int'(clk);
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            mon_e = exp_q.pop_front();
            checkOutput("sb_missed_edge", int'(clk), mon_e.lvl);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic applyStimulus(input int b, input logic [31:0] pattern, input int len);
        for (int i = 0; i < len; i++) begin
            @(negedge clk_i);
            set_raw(b, pattern[i]);
        end
        @(negedge clk_i);
        set_raw(b, 1'b0);
    endtask

    task automatic wait_rises(input int n);
        int target;
        int waited;
        target = rise_count + n;
        waited = 0;
        while (rise_count < target && waited < 400) begin
            @(posedge clk_i);
            #2;
            waited++;
        end
        if (rise_count < target) checkOutput("rise_timeout", rise_count, target);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk_i);
        #2;
    endtask

    task automatic pulse_reset(input string name);
        @(posedge clk_i);
        #2;
        rst = 1'b0;
        #1;
        checkOutput(name, int'(clk), 0);
        exp_q.delete();
        repeat (3) @(negedge clk_i);
        rst = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    int rc;
    int hold[3];
    int lvl[3];

    initial begin
        #1 rst = 1'b0;
        #1 checkOutput("reset_clk_async", int'(clk), 0);
        wait_cycles(4);
        checkOutput("reset_clk_held", int'(clk), 0);
        @(negedge clk_i);
        rst = 1'b1;

        rc = rise_count;
        wait_cycles(100);
        checkOutput("idle_no_rise", rise_count - rc, 0);
        checkOutput("idle_clk_low", int'(clk), 0);

        applyStimulus(0, 32'h3F, 6);
        wait_rises(3);
        checkOutput("period_speed0", last_period, 16);
        for (int s = 1; s <= 4; s++) begin
            applyStimulus(2, 32'h3F, 6);
            wait_cycles(4);
            wait_rises(3);
            checkOutput($sformatf("period_after_speed_press%0d", s), last_period, 2 * (HB >> (s % 4)));
        end

        wait_rises(1);
        applyStimulus(0, 32'h3F, 6);
        wait_cycles(6);
        checkOutput("halt_clk_low", int'(clk), 0);
        checkOutput("halt_high_phase", last_high, 8);
        rc = rise_count;
        wait_cycles(40);
        checkOutput("halt_no_rise", rise_count - rc, 0);

        rc = rise_count;
        applyStimulus(1, 32'h3F0F, 14);
        wait_cycles(30);
        checkOutput("step_single_rise", rise_count - rc, 1);
        checkOutput("step_high_width", last_high, 8);
        checkOutput("step_clk_low", int'(clk), 0);

        rc = rise_count;
        for (int b = 0; b < 3; b++) begin
            applyStimulus(b, 32'h7, 3);
            wait_cycles(10);
        end
        wait_cycles(20);
        checkOutput("glitch_no_rise", rise_count - rc, 0);

        applyStimulus(0, 32'h3FD, 10);
        wait_rises(3);
        checkOutput("bounce_period", last_period, 16);

        applyStimulus(2, 32'h3F, 6);
        wait_cycles(4);
        wait_rises(3);
        checkOutput("pre_reset_period", last_period, 8);
        wait_rises(1);
        checkOutput("pre_reset_clk_high", int'(clk), 1);
        pulse_reset("reset_async_drop");
        rc = rise_count;
        wait_cycles(40);
        checkOutput("post_reset_halted", rise_count - rc, 0);
        applyStimulus(0, 32'h3F, 6);
        wait_rises(3);
        checkOutput("post_reset_period", last_period, 16);

        for (int b = 0; b < 3; b++) begin
            hold[b] = 0;
            lvl[b]  = 0;
        end
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_i);
            for (int b = 0; b < 3; b++) begin
                if (hold[b] == 0) begin
                    lvl[b]  = int'($urandom_range(0, 1));
                    hold[b] = int'($urandom_range(1, 16));
                end
                hold[b]--;
                set_raw(b, lvl[b][0]);
            end
            if (c == 1500) pulse_reset("random_reset_drop");
        end
        for (int b = 0; b < 3; b++) set_raw(b, 1'b0);
        wait_cycles(60);
        checkOutput("sb_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
